gray_to_bin_serial: RTL

- Gray-code-to-binary decoder. It is the receive-side counterpart of the team's binary-to-Gray encoder.
- Accepts one W-bit Gray word through a valid/ready handshake.
- Decodes it bit-serially, MSB first, one bit per clock, using b[i] = b[i+1] ^ g[i] with b[W-1] = g[W-1].
- Presents the binary word through a valid/ready output handshake.
- Sits between Gray-coded sources (position counters, CDC pointers) and binary consumers.

---
 rtl/gray_to_bin_serial.sv | 100 ++++++++++
 1 files changed

// File: rtl/gray_to_bin_serial.sv
// gray_to_bin_serial: bit-serial Gray-to-binary decoder (MSB first) with valid/ready handshakes.
//   clk/rst_n   : clock, asynchronous active-low reset
//   in_valid/in_ready/in_gray    : input word handshake (Gray-coded, W bits)
//   out_valid/out_ready/out_bin  : output word handshake (binary, W bits)
//   busy        : high while decoding
//   step_err    : Gray step violation; built only when GRAY_STEP_CHECK_EN is defined, else tied 0
module gray_to_bin_serial #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_gray,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_bin,
  output logic         busy,
  output logic         step_err
);
  localparam int IW = (W > 1) ? $clog2(W) : 1;
  typedef enum logic [1:0] {IDLE, DECODE, DONE} state_t;
  state_t         state_q, state_d;
  logic [W-1:0]   g_q, g_d, work_q, work_d, out_bin_q, out_bin_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           acc_q, acc_d, accept, bit_v;
  assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = state_q == DONE;
  assign busy      = state_q == DECODE;
  assign out_bin   = out_bin_q;
  assign bit_v     = acc_q ^ g_q[idx_q];
  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    work_d    = work_q;
    out_bin_d = out_bin_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    if (accept) begin
      g_d     = in_gray;
      idx_d   = IW'(W - 1);
      acc_d   = 1'b0;
      work_d  = '0;
      state_d = DECODE;
    end else if (state_q == DECODE) begin
      work_d[idx_q] = bit_v;
      acc_d         = bit_v;
      idx_d         = idx_q - IW'(1);
      if (idx_q == '0) begin
        out_bin_d = work_d;
        state_d   = DONE;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      g_q       <= '0;
      work_q    <= '0;
      out_bin_q <= '0;
      idx_q     <= '0;
      acc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      work_q    <= work_d;
      out_bin_q <= out_bin_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
    end
  end
`ifdef GRAY_STEP_CHECK_EN
  logic [W-1:0] prev_q, diff;
  logic         have_prev_q, pend_q, step_err_q, one_hot;
  // popcount == 1 is exactly "nonzero and a power of two"
  assign diff     = in_gray ^ prev_q;
  assign one_hot  = (diff != '0) && ((diff & (diff - W'(1))) == '0);
  assign step_err = step_err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      pend_q      <= 1'b0;
      step_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        prev_q      <= in_gray;
        have_prev_q <= 1'b1;
        pend_q      <= have_prev_q && !one_hot;
      end
      if (state_q == DECODE && idx_q == '0) step_err_q <= pend_q;
    end
  end
`else
  assign step_err = 1'b0;
`endif
endmodule
